// File: rtl/div_clk_meter_pkg.sv
// Shared definitions for the divided-clock meter.
//   meter_state_t  : measurement FSM states (IDLE / ARM / RUN)
//   MIN_PERIOD_HC  : shortest period (half-cycles) a clk divider can produce
//                    with divide-by-2 or more; anything shorter is "too fast"
package div_clk_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } meter_state_t;

    localparam int MIN_PERIOD_HC = 4;

endpackage

// File: rtl/dual_edge_sampler.sv
// Samples div_clk on both edges of clk and presents one posedge worth of
// half-samples to the posedge logic.
//   clk, rst_n : system clock, asynchronous active-low reset
//   div_clk    : divided clock under measurement
//   h0         : half-sample taken on the preceding negedge (older)
//   h1         : half-sample taken on this posedge (newer)
//   e0, e1     : rising-edge flags for h0 and h1 respectively
module dual_edge_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic div_clk,
    output logic h0,
    output logic h1,
    output logic e0,
    output logic e1
);

    logic s_neg;
    logic last_q;   // h1 of the previous posedge, i.e. the half-sample before h0

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) s_neg <= 1'b0;
        else        s_neg <= div_clk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b0;
        else        last_q <= div_clk;
    end

    assign h0 = s_neg;
    assign h1 = div_clk;
    assign e0 = s_neg & ~last_q;
    assign e1 = div_clk & ~s_neg;

endmodule

// File: rtl/div_clk_meter.sv
// In-system checker for a divided clock derived from clk.
// Measures period and high time with half-cycle resolution and reports
// division ratio, exact-50%-duty, lock, timeout and too-fast status.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   div_clk     : divided clock (glitch-free, generated from clk)
//   meas_valid  : 1-cycle pulse, new measurement on the outputs
//   period_hc   : last period in half-cycles
//   high_hc     : half-samples reading 1 within that period
//   div_ratio   : period_hc >> 1
//   ratio_odd   : div_ratio[0]
//   duty_ok     : high time is exactly half the period
//   locked      : LOCK_CNT consecutive identical periods
//   timeout     : 1-cycle pulse, no rising edge for 2^CNT_W-1 half-cycles
//   too_fast    : sticky, a period below MIN_PERIOD_HC was seen
//   fsm_state   : current measurement state, for observation
module div_clk_meter
    import div_clk_meter_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               div_clk,
    output logic               meas_valid,
    output logic [CNT_W-1:0]   period_hc,
    output logic [CNT_W-1:0]   high_hc,
    output logic [CNT_W-2:0]   div_ratio,
    output logic               ratio_odd,
    output logic               duty_ok,
    output logic               locked,
    output logic               timeout,
    output logic               too_fast,
    output meter_state_t       fsm_state
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W:0]   CNT_MAX  = {1'b0, {CNT_W{1'b1}}};
    localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD_HC);

    logic h0, h1, e0, e1;

    dual_edge_sampler u_sampler (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_clk (div_clk),
        .h0      (h0),
        .h1      (h1),
        .e0      (e0),
        .e1      (e1)
    );

    meter_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, high_q, high_d;
    logic [CNT_W-1:0] meas_period, meas_high;
    logic [CNT_W:0]   sum_cnt, sum_high;
    logic             cnt_full, edge_seen, meas, tmo;
    logic [MW-1:0]    mcnt_q, mcnt_d;

    // Counters: cnt_q counts half-samples since the last rising-edge sample
    // (inclusive), high_q those that read 1. An edge on h0 closes the period
    // before h0; an edge on h1 closes it after h0, so h0 still belongs to it.
    always_comb begin
        sum_cnt     = {1'b0, cnt_q} + (CNT_W+1)'(2);
        sum_high    = {1'b0, high_q} + (CNT_W+1)'(h0) + (CNT_W+1)'(h1);
        cnt_full    = (sum_cnt >= CNT_MAX);
        edge_seen   = e0 | e1;
        meas_period = '0;
        meas_high   = '0;
        cnt_d       = (sum_cnt > CNT_MAX)  ? CNT_MAX[CNT_W-1:0] : sum_cnt[CNT_W-1:0];
        high_d      = (sum_high > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_high[CNT_W-1:0];
        if (e0) begin
            meas_period = cnt_q;
            meas_high   = high_q;
            cnt_d       = CNT_W'(2);
            high_d      = CNT_W'(1) + CNT_W'(h1);
        end else if (e1) begin
            meas_period = cnt_q + CNT_W'(1);
            meas_high   = high_q + CNT_W'(h0);
            cnt_d       = CNT_W'(1);
            high_d      = CNT_W'(1);
        end
    end

    // Measurement FSM
    always_comb begin
        state_d = state_q;
        meas    = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ST_IDLE: if (edge_seen) state_d = ST_ARM;
            ST_ARM, ST_RUN: begin
                if (edge_seen) begin
                    meas    = 1'b1;
                    state_d = ST_RUN;
                end else if (cnt_full) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lock counter: consecutive measurements equal to the previous period
    always_comb begin
        mcnt_d = mcnt_q;
        if (meas_period != period_hc)  mcnt_d = MW'(1);
        else if (mcnt_q != LOCK_MAX)   mcnt_d = mcnt_q + MW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_q     <= '0;
            mcnt_q     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            period_hc  <= '0;
            high_hc    <= '0;
            duty_ok    <= 1'b0;
            locked     <= 1'b0;
            too_fast   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_q     <= high_d;
            meas_valid <= meas;
            timeout    <= tmo;
            if (meas) begin
                period_hc <= meas_period;
                high_hc   <= meas_high;
                duty_ok   <= ({meas_high, 1'b0} == {1'b0, meas_period});
                mcnt_q    <= mcnt_d;
                locked    <= (mcnt_d == LOCK_MAX) && (meas_period >= MIN_P);
                if (meas_period < MIN_P) too_fast <= 1'b1;
            end else if (tmo) begin
                mcnt_q <= '0;
                locked <= 1'b0;
            end
        end
    end

    assign div_ratio = period_hc[CNT_W-1:1];
    assign ratio_odd = period_hc[1];
    assign fsm_state = state_q;

endmodule

// File: tb/tb_div_clk_meter.sv
// Bench for div_clk_meter: drives div_clk as a stream of half-cycle values,
// compares every cycle against a half-sample-stream reference model.
module tb_div_clk_meter;
  import div_clk_meter_pkg::*;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int TMO_HC   = 255;
  localparam int MIN_P    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic div_clk = 1'b0;
  always #5 clk = ~clk;

  logic             meas_valid, ratio_odd, duty_ok, locked, timeout, too_fast;
  logic [CNT_W-1:0] period_hc, high_hc;
  logic [CNT_W-2:0] div_ratio;
  meter_state_t     fsm_state;

  div_clk_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_clk    (div_clk),
    .meas_valid (meas_valid),
    .period_hc  (period_hc),
    .high_hc    (high_hc),
    .div_ratio  (div_ratio),
    .ratio_odd  (ratio_odd),
    .duty_ok    (duty_ok),
    .locked     (locked),
    .timeout    (timeout),
    .too_fast   (too_fast),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passed = 0;
  logic [2*CNT_W-1:0] exp_q[$];

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit hs_q[$];        // every half-sample since reset
  bit pend_q[$];      // half-samples waiting to be driven as a pair
  int hist_q[$];      // periods measured since reset / timeout
  int last_edge;
  bit armed;
  int exp_period, exp_high;
  bit exp_duty, exp_locked, exp_too_fast;

  // observation bookkeeping for directed checks
  int tmo_seen, valid_seen, lock_rise_at, last_valid_period;
  int mm_period, mm_locked, mm_valid;
  bit was_locked;

  task automatic model_reset();
    hs_q.delete(); hist_q.delete(); exp_q.delete(); pend_q.delete();
    armed = 0; last_edge = 0;
    exp_period = 0; exp_high = 0; exp_duty = 0; exp_locked = 0; exp_too_fast = 0;
    tmo_seen = 0; valid_seen = 0; lock_rise_at = -1; last_valid_period = 0;
    was_locked = 0;
  endtask

  task automatic model_pair(input bit a, input bit b, output bit m, output bit t);
    int base, edge_at, p, h;
    bit pv;
    base = hs_q.size();
    edge_at = -1;
    hs_q.push_back(a);
    hs_q.push_back(b);
    for (int i = base; i < base + 2; i++) begin
      pv = 1'b0;
      if (i > 0) pv = hs_q[i-1];
      if (hs_q[i] && !pv) edge_at = i;
    end
    m = 0;
    t = 0;
    if (edge_at >= 0) begin
      if (armed) begin
        p = edge_at - last_edge;
        h = 0;
        for (int k = last_edge; k < edge_at; k++) h += int'(hs_q[k]);
        m = 1;
        exp_period = p;
        exp_high = h;
        exp_duty = (2 * h == p);
        hist_q.push_back(p);
        exp_locked = 0;
        if (hist_q.size() >= LOCK_CNT && p >= MIN_P) begin
          exp_locked = 1;
          for (int k = hist_q.size() - LOCK_CNT; k < hist_q.size(); k++)
            if (hist_q[k] != p) exp_locked = 0;
        end
        if (p < MIN_P) exp_too_fast = 1;
        exp_q.push_back({CNT_W'(p), CNT_W'(h)});
      end
      armed = 1;
      last_edge = edge_at;
    end else if (armed && (base + 2 - last_edge) >= TMO_HC) begin
      t = 1;
      armed = 0;
      exp_locked = 0;
      hist_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a posedge; returns #1 after the posedge that processed (a,b).
  task automatic cycle(input bit a, input bit b);
    bit m, t;
    logic [2*CNT_W-1:0] w;
    div_clk = a;
    @(negedge clk);
    #1 div_clk = b;
    @(posedge clk);
    #1;
    model_pair(a, b, m, t);
    check("meas_valid", meas_valid, m);
    check("timeout", timeout, t);
    check("period_hc", period_hc, exp_period);
    check("high_hc", high_hc, exp_high);
    check("div_ratio", div_ratio, exp_period / 2);
    check("ratio_odd", ratio_odd, (exp_period / 2) % 2);
    check("duty_ok", duty_ok, exp_duty);
    check("locked", locked, exp_locked);
    check("too_fast", too_fast, exp_too_fast);
    if (meas_valid && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("sb_meas", {period_hc, high_hc}, w);
    end
    if (timeout) tmo_seen++;
    if (meas_valid) begin
      valid_seen++;
      if (int'(period_hc) != last_valid_period) begin
        mm_period = period_hc;
        mm_locked = locked;
        mm_valid = valid_seen;
      end
      last_valid_period = period_hc;
    end
    if (locked && !was_locked) lock_rise_at = valid_seen;
    was_locked = locked;
  endtask

  task automatic put(input bit v);
    bit a, b;
    pend_q.push_back(v);
    if (pend_q.size() == 2) begin
      a = pend_q.pop_front();
      b = pend_q.pop_front();
      cycle(a, b);
    end
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) put(1'b1);
      for (int i = 0; i < lo; i++) put(1'b0);
    end
  endtask

  task automatic hold(input bit v, input int halves);
    for (int i = 0; i < halves; i++) put(v);
  endtask

  // Called #1 after a posedge; releases reset #1 after a later posedge.
  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_meas_valid", meas_valid, 0);
    check("rst_period", period_hc, 0);
    check("rst_high", high_hc, 0);
    check("rst_ratio", div_ratio, 0);
    check("rst_odd", ratio_odd, 0);
    check("rst_duty", duty_ok, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout, 0);
    check("rst_too_fast", too_fast, 0);
    check("rst_state", fsm_state, ST_IDLE);
    model_reset();
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int v0;

  initial begin
    model_reset();
    mm_period = 0; mm_locked = 0; mm_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset(2);

    // divide-by-5, 50% duty
    wave(5, 5, 6);
    check("d5_period", period_hc, 10);
    check("d5_high", high_hc, 5);
    check("d5_ratio", div_ratio, 5);
    check("d5_odd", ratio_odd, 1);
    check("d5_duty", duty_ok, 1);
    check("d5_locked", locked, 1);
    check("d5_lock_at", lock_rise_at, 4);

    // divide-by-4
    wave(4, 4, 6);
    check("d4_period", period_hc, 8);
    check("d4_high", high_hc, 4);
    check("d4_ratio", div_ratio, 4);
    check("d4_odd", ratio_odd, 0);
    check("d4_duty", duty_ok, 1);

    // divide-by-3, high for one clk
    wave(2, 4, 6);
    check("d3_period", period_hc, 6);
    check("d3_high", high_hc, 2);
    check("d3_duty", duty_ok, 0);

    // locked on div-5, then switch to div-7
    wave(5, 5, 6);
    check("sw_locked5", locked, 1);
    wave(7, 7, 6);
    check("sw_mm_period", mm_period, 14);
    check("sw_mm_locked", mm_locked, 0);
    check("sw_relock_at", lock_rise_at, mm_valid + 3);

    // stuck low for 200 cycles
    tmo_seen = 0;
    hold(1'b0, 400);
    check("low_tmo_count", tmo_seen, 1);
    check("low_locked", locked, 0);
    v0 = valid_seen;
    wave(5, 5, 3);
    check("low_recover_valids", valid_seen - v0, 2);

    // stuck high
    wave(5, 5, 4);
    tmo_seen = 0;
    hold(1'b1, 400);
    check("high_tmo_count", tmo_seen, 1);
    hold(1'b0, 4);

    // reset mid-period while locked
    wave(6, 6, 6);
    hold(1'b1, 4);
    check("mid_locked", locked, 1);
    apply_reset(1);
    wave(6, 6, 1);
    check("mid_no_valid", valid_seen, 0);
    hold(1'b1, 2);
    check("mid_first_valid", valid_seen, 1);
    check("mid_first_period", period_hc, 12);
    hold(1'b1, 4);
    hold(1'b0, 6);

    // periods around the timeout limit
    wave(127, 127, 3);
    wave(128, 127, 3);
    wave(128, 128, 2);

    // randomized segments
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 9) == 0)
        wave($urandom_range(100, 130), $urandom_range(100, 130), 1);
      else if ($urandom_range(0, 2) == 0)
        wave($urandom_range(2, 10), 0, 0) ;
      else begin
        int hi;
        hi = $urandom_range(2, 12);
        if ($urandom_range(0, 1) == 1) wave(hi, hi, $urandom_range(3, 7));
        else wave(hi, $urandom_range(2, 12), $urandom_range(1, 6));
      end
    end

    // too fast: periods of 2 and 3 half-cycles
    wave(1, 1, 6);
    wave(1, 2, 4);
    check("fast_sticky", too_fast, 1);
    check("fast_locked", locked, 0);
    hold(1'b0, 20);
    wave(4, 4, 4);
    check("fast_still_sticky", too_fast, 1);
    if (pend_q.size() > 0) put(1'b0);

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
